// File: rtl/smartcargo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : smartcargo_pkg                                         |
// | Shared sizing constants and object type for the SmartCargo       |
// | elevator cargo store.                                            |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package smartcargo_pkg;

    localparam int DEPTH   = 8;                  // number of cargo slots
    localparam int TIPO_W  = 2;                  // object-type field width
    localparam int DEST_W  = 2;                  // destination-floor width
    localparam int ENTRY_W = TIPO_W + DEST_W;    // one stored entry
    localparam int CNT_W   = $clog2(DEPTH) + 1;  // holds 0..DEPTH

    // tipo sits in the MSBs of a stored entry
    typedef struct packed {
        logic [TIPO_W-1:0] tipo;
        logic [DEST_W-1:0] destino;
    } objeto_t;

endpackage
`default_nettype wire

// File: rtl/conteudo_elevador_ram_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : conteudo_elevador_ram_if                             |
// | Request/response bundle between the loading datapath / control   |
// | FSM (master) and the cargo-content store (slave).                |
// | Optional status signals under RAM_CONTEUDO_STATUS_EN.            |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
interface conteudo_elevador_ram_if
    import smartcargo_pkg::*;
;
    logic [TIPO_W-1:0] in_tipo_objeto;
    logic [DEST_W-1:0] in_destino_objeto;
    logic              weT;
    logic              shift;
    logic              tira_objetos;
    logic [DEST_W-1:0] andar_atual;
    logic [TIPO_W-1:0] tipo_objeto;
    logic [DEST_W-1:0] destino_objeto;
`ifdef RAM_CONTEUDO_STATUS_EN
    logic [CNT_W-1:0]  count;
    logic              vazio;
    logic              cheio;

    modport master (
        output in_tipo_objeto, in_destino_objeto, weT, shift, tira_objetos, andar_atual,
        input  tipo_objeto, destino_objeto, count, vazio, cheio
    );
    modport slave (
        input  in_tipo_objeto, in_destino_objeto, weT, shift, tira_objetos, andar_atual,
        output tipo_objeto, destino_objeto, count, vazio, cheio
    );
`else
    modport master (
        output in_tipo_objeto, in_destino_objeto, weT, shift, tira_objetos, andar_atual,
        input  tipo_objeto, destino_objeto
    );
    modport slave (
        input  in_tipo_objeto, in_destino_objeto, weT, shift, tira_objetos, andar_atual,
        output tipo_objeto, destino_objeto
    );
`endif

endinterface
`default_nettype wire

// File: rtl/conteudo_compactor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : conteudo_compactor                                      |
// | Combinational stable compaction: every kept entry moves to the   |
// | slot equal to the number of kept entries below it; unused slots  |
// | are zero. Also returns the number of kept entries.               |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module conteudo_compactor
    import smartcargo_pkg::*;
#(
    parameter int N = DEPTH
)
(
    input  objeto_t [N-1:0]      i_entries,
    input  logic    [N-1:0]      i_keep,
    output objeto_t [N-1:0]      o_entries,
    output logic    [$clog2(N):0] o_count
);

    localparam int c_IDX_W = $clog2(N);

    logic [$clog2(N):0] w_rank;

    // Walk slots low to high; the running rank is the prefix count of kept entries
    always_comb begin
        o_entries = '0;
        w_rank    = '0;
        for (int i = 0; i < N; i++) begin
            if (i_keep[i]) begin
                o_entries[w_rank[c_IDX_W-1:0]] = i_entries[i];
                w_rank = w_rank + ($clog2(N)+1)'(1);
            end
        end
        o_count = w_rank;
    end

endmodule
`default_nettype wire

// File: rtl/conteudo_elevador_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : conteudo_elevador_ram                                   |
// | Ordered cargo list of the SmartCargo elevator. Objects are       |
// | appended at the tail, popped from the head and unloaded in bulk  |
// | by destination floor. Head entry drives the outputs.             |
// | Optional macro RAM_CONTEUDO_STATUS_EN adds count/vazio/cheio.    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module conteudo_elevador_ram
    import smartcargo_pkg::*;
(
    input  logic                   clk,
    input  logic                   clear_n,
    conteudo_elevador_ram_if.slave bus
);

    localparam int c_IDX_W = $clog2(DEPTH);

    objeto_t [DEPTH-1:0] r_ram;
    objeto_t [DEPTH-1:0] w_ram_nxt;
    objeto_t [DEPTH-1:0] w_cmp_ram;
    logic    [DEPTH-1:0] r_valid;
    logic    [DEPTH-1:0] w_valid_nxt;
    logic    [DEPTH-1:0] w_match;
    logic    [DEPTH-1:0] w_keep;
    logic    [CNT_W-1:0] r_count;
    logic    [CNT_W-1:0] w_count_nxt;
    logic    [CNT_W-1:0] w_cmp_count;
    logic    [CNT_W-1:0] w_count_m1;
    objeto_t             w_novo;
    logic                w_vazio;
    logic                w_cheio;

    assign w_novo     = '{tipo: bus.in_tipo_objeto, destino: bus.in_destino_objeto};
    assign w_vazio    = (r_count == '0);
    assign w_cheio    = (r_count == CNT_W'(DEPTH));
    assign w_count_m1 = r_count - CNT_W'(1);

    // A slot is unloaded only if it holds a real object bound for this floor
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_match
            assign w_match[i] = r_valid[i] && (r_ram[i].destino == bus.andar_atual);
        end
    endgenerate

    // Unload drops matching entries; a pop is the same compaction with slot 0 dropped
    assign w_keep = bus.tira_objetos ? (r_valid & ~w_match)
                                     : (r_valid & {{(DEPTH-1){1'b1}}, 1'b0});

    conteudo_compactor #(
        .N (DEPTH)
    ) u_compactor (
        .i_entries (r_ram),
        .i_keep    (w_keep),
        .o_entries (w_cmp_ram),
        .o_count   (w_cmp_count)
    );

    // Next contents: unload wins, then pop (optionally with append), then append
    always_comb begin
        w_ram_nxt   = r_ram;
        w_count_nxt = r_count;
        if (bus.tira_objetos) begin
            w_ram_nxt   = w_cmp_ram;
            w_count_nxt = w_cmp_count;
        end else if (bus.shift && !w_vazio) begin
            w_ram_nxt   = w_cmp_ram;
            w_count_nxt = w_count_m1;
            if (bus.weT) begin
                // after the pop, slot count-1 is the first free slot
                w_ram_nxt[w_count_m1[c_IDX_W-1:0]] = w_novo;
                w_count_nxt = r_count;
            end
        end else if (bus.weT && !w_cheio) begin
            w_ram_nxt[r_count[c_IDX_W-1:0]] = w_novo;
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    // Valid slots always form the prefix 0..count-1
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_valid
            assign w_valid_nxt[i] = (CNT_W'(i) < w_count_nxt);
        end
    endgenerate

    // Storage, validity and occupancy registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_ram   <= '0;
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_ram   <= w_ram_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Head entry is the object of the turn; zero when nothing is loaded
    assign bus.tipo_objeto    = w_vazio ? '0 : r_ram[0].tipo;
    assign bus.destino_objeto = w_vazio ? '0 : r_ram[0].destino;

`ifdef RAM_CONTEUDO_STATUS_EN
    assign bus.count = r_count;
    assign bus.vazio = w_vazio;
    assign bus.cheio = w_cheio;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conteudo_elevador_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_conteudo_elevador_ram                                |
// | Self-checking bench: directed scenarios with literal images plus |
// | randomized traffic against a queue-based list model.             |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_conteudo_elevador_ram;
    import smartcargo_pkg::*;

    localparam int c_IMG_W = DEPTH * ENTRY_W;

    logic clk;
    logic clear_n;
    logic cmp_en;
    int   n_checks;
    int   n_errors;

    logic [ENTRY_W-1:0] q[$];   // model: ordered list, head at index 0

    conteudo_elevador_ram_if tif ();

    conteudo_elevador_ram dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input bit [63:0] act, input bit [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit [c_IMG_W-1:0] model_img();
        bit [c_IMG_W-1:0] img = '0;
        for (int i = 0; i < q.size(); i++) img[i*ENTRY_W +: ENTRY_W] = q[i];
        return img;
    endfunction

    function automatic bit [c_IMG_W-1:0] dut_img();
        bit [c_IMG_W-1:0] img;
        img = dut.r_ram;
        return img;
    endfunction

    // One request set for exactly one rising edge, then the model applies the list rules
    task automatic op(input bit w, input bit s, input bit t, input int andar,
                      input int tipo, input int dest);
        logic [ENTRY_W-1:0] nq[$];
        logic [ENTRY_W-1:0] novo;
        tif.weT               = w;
        tif.shift             = s;
        tif.tira_objetos      = t;
        tif.andar_atual       = DEST_W'(andar);
        tif.in_tipo_objeto    = TIPO_W'(tipo);
        tif.in_destino_objeto = DEST_W'(dest);
        novo = {TIPO_W'(tipo), DEST_W'(dest)};
        @(posedge clk);
        if (t) begin
            foreach (q[i]) if (q[i][DEST_W-1:0] != DEST_W'(andar)) nq.push_back(q[i]);
            q = nq;
        end else if (s && q.size() > 0) begin
            void'(q.pop_front());
            if (w) q.push_back(novo);
        end else if (w && q.size() < DEPTH) begin
            q.push_back(novo);
        end
        #1;
        tif.weT          = 1'b0;
        tif.shift        = 1'b0;
        tif.tira_objetos = 1'b0;
    endtask

    task automatic async_reset();
        #1 clear_n = 1'b0;
        #1;
        q.delete();
        chk("async_rst_img", dut_img(), 0);
        chk("async_rst_tipo", tif.tipo_objeto, 0);
        chk("async_rst_dest", tif.destino_objeto, 0);
        #1 clear_n = 1'b1;
    endtask

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("head_tipo", tif.tipo_objeto,
                (q.size() > 0) ? q[0][ENTRY_W-1:DEST_W] : 0);
            chk("head_dest", tif.destino_objeto,
                (q.size() > 0) ? q[0][DEST_W-1:0] : 0);
            chk("count", dut.r_count, q.size());
            chk("valid", dut.r_valid, (64'd1 << q.size()) - 1);
            chk("ram_img", dut_img(), model_img());
`ifdef RAM_CONTEUDO_STATUS_EN
            chk("st_count", tif.count, q.size());
            chk("st_vazio", tif.vazio, q.size() == 0);
            chk("st_cheio", tif.cheio, q.size() == DEPTH);
`endif
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cmp_en   = 1'b0;
        tif.weT = 1'b0; tif.shift = 1'b0; tif.tira_objetos = 1'b0;
        tif.andar_atual = '0; tif.in_tipo_objeto = '0; tif.in_destino_objeto = '0;
        clear_n = 1'b0;

        // Reset state
        #3;
        chk("rst_img", dut_img(), 0);
        chk("rst_tipo", tif.tipo_objeto, 0);
        chk("rst_dest", tif.destino_objeto, 0);
        chk("rst_count", dut.r_count, 0);
        #9 clear_n = 1'b1;
        @(posedge clk);
        #1 cmp_en = 1'b1;

        // Fill, then one append too many
        for (int i = 0; i < 8; i++) op(1, 0, 0, 0, i & 3, (i + 1) & 3);
        op(1, 0, 0, 0, 3, 3);
        chk("fill_model", model_img(), 32'hCB61CB61);
        chk("fill_dut", dut_img(), 32'hCB61CB61);
        chk("fill_count", dut.r_count, 8);

        // Bulk unload floor by floor
        op(0, 0, 1, 0, 0, 0);
        chk("tira0_model", model_img(), 32'h00B61B61);
        chk("tira0_dut", dut_img(), 32'h00B61B61);
        chk("tira0_count", dut.r_count, 6);
        op(0, 0, 1, 1, 0, 0);
        chk("tira1_dut", dut_img(), 32'h0000B6B6);
        op(0, 0, 1, 2, 0, 0);
        chk("tira2_dut", dut_img(), 32'h000000BB);
        op(0, 0, 1, 3, 0, 0);
        chk("tira3_dut", dut_img(), 0);
        chk("tira3_count", dut.r_count, 0);

        // Pop, then pop+append
        op(1, 0, 0, 0, 0, 1);
        op(1, 0, 0, 0, 1, 2);
        op(1, 0, 0, 0, 2, 3);
        op(0, 1, 0, 0, 0, 0);
        chk("shift_tipo", tif.tipo_objeto, 1);
        chk("shift_dest", tif.destino_objeto, 2);
        op(1, 1, 0, 0, 3, 3);
        chk("shwe_model", model_img(), 32'h000000FB);
        chk("shwe_dut", dut_img(), 32'h000000FB);
        chk("shwe_count", dut.r_count, 2);

        // Empty-list corner cases
        op(0, 0, 1, 3, 0, 0);
        op(0, 1, 0, 0, 0, 0);
        op(0, 0, 1, 1, 0, 0);
        op(1, 0, 1, 2, 1, 1);
        chk("empty_count", dut.r_count, 0);
        op(1, 1, 0, 0, 2, 1);
        chk("empty_shwe_img", dut_img(), 32'h00000009);

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 600; n++) begin
            op(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 8) == 0,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            if (($urandom % 97) == 0) async_reset();
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
